noc_local_inject_arbiter: RTL and testbench

Parametrised local-injection stage for the NoC fabric nodes. It buffers flits from `NUM_CH` independent upstream channels in per-channel FIFOs and arbitrates them onto one sender link. Arbitration is wormhole-style: a packet holds the link from its header flit to its tail flit, and the next packet is chosen round-robin. It sits between a node's local receive channels and the router-facing sender port, replacing the fixed two-channel, pass-through connection.

---
 rtl/noc_local_inject_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_noc_local_inject_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_inject_arbiter.sv
// Local-injection stage: per-channel FIFOs feeding one sender link with wormhole round-robin
// arbitration. Optional head-flit drop and error counter enabled by NOC_INJ_ERR_DROP_EN.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_local_inject_arbiter #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FLIT_W     = `Noc_Data_Width,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CH_W      = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                     noc_clk,
    input  logic                     noc_rst,
    input  logic [NUM_CH-1:0]        ch_receive_valid,
    output logic [NUM_CH-1:0]        ch_receive_ready,
    input  logic [NUM_CH*FLIT_W-1:0] ch_receive_flit,
    output logic [NUM_CH-1:0]        ch_receive_vc_ready,
    input  logic [NUM_CH-1:0]        ch_receive_is_header,
    input  logic [NUM_CH-1:0]        ch_receive_is_tail,
    output logic                     sender_valid,
    input  logic                     sender_ready,
    output logic [FLIT_W-1:0]        sender_flit,
    input  logic                     sender_vc_ready,
    output logic                     sender_is_header,
    output logic                     sender_is_tail,
    output logic [CH_W-1:0]          sender_ch_id
`ifdef NOC_INJ_ERR_DROP_EN
    ,
    output logic [15:0]              err_cnt
`endif
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = FLIT_W + 2;

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e            state_q;
    logic [CH_W-1:0]   grant_q, rr_ptr_q, pick, rr_next;
    logic              found, lock_valid;
    int unsigned       idx;

    logic [EW-1:0]     mem_q [NUM_CH][FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q [NUM_CH];
    logic [AW:0]       rd_ptr_q [NUM_CH];
    logic [FLIT_W-1:0] head_flit [NUM_CH];
    logic [NUM_CH-1:0] empty, full, push, pop, drop, cand, head_hdr, head_tail;

    always_comb begin
        empty     = '0;
        full      = '0;
        push      = '0;
        cand      = '0;
        head_hdr  = '0;
        head_tail = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                       (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            {head_hdr[i], head_tail[i], head_flit[i]} = mem_q[i][rd_ptr_q[i][AW-1:0]];
            push[i]  = ch_receive_valid[i] && !full[i] && !noc_rst;
            cand[i]  = !empty[i] && head_hdr[i];
        end
    end

    assign lock_valid = (state_q == StLocked) && !empty[grant_q];

    // Non-header heads can never win arbitration; optionally they are discarded while idle.
    always_comb begin
        drop = '0;
`ifdef NOC_INJ_ERR_DROP_EN
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            drop[i] = (state_q == StIdle) && !empty[i] && !head_hdr[i];
        end
`endif
        pop = drop;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (lock_valid && sender_ready && grant_q == CH_W'(i)) begin
                pop[i] = 1'b1;
            end
        end
    end

    // Round-robin search starting at rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_CH;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
    end

    assign rr_next = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sender_vc_ready && found) begin
                        grant_q <= pick;
                        state_q <= StLocked;
                    end
                end
                StLocked: begin
                    if (pop[grant_q] && head_tail[grant_q]) begin
                        state_q  <= StIdle;
                        rr_ptr_q <= rr_next;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (push[i]) begin
                    mem_q[i][wr_ptr_q[i][AW-1:0]] <= {ch_receive_is_header[i],
                                                      ch_receive_is_tail[i],
                                                      ch_receive_flit[i*FLIT_W +: FLIT_W]};
                    wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef NOC_INJ_ERR_DROP_EN
    logic [15:0] err_cnt_q;
    logic [16:0] err_sum;

    assign err_sum = 17'(err_cnt_q) + 17'($countones(drop));

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign err_cnt = noc_rst ? '0 : err_cnt_q;
`endif

    always_comb begin
        ch_receive_ready    = noc_rst ? '0 : ~full;
        ch_receive_vc_ready = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_receive_vc_ready[i] = !noc_rst && empty[i] &&
                                     !(state_q == StLocked && grant_q == CH_W'(i));
        end
        sender_valid     = !noc_rst && lock_valid;
        sender_flit      = '0;
        sender_is_header = 1'b0;
        sender_is_tail   = 1'b0;
        if (!noc_rst && lock_valid) begin
            sender_flit      = head_flit[grant_q];
            sender_is_header = head_hdr[grant_q];
            sender_is_tail   = head_tail[grant_q];
        end
        sender_ch_id = noc_rst ? '0 : grant_q;
    end

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Bench for noc_local_inject_arbiter: per-cycle vector table plus handshake-driven sequences.
module tb_noc_local_inject_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  v, h, t, rrdy, vcr;
    logic [15:0] flits;
    logic        srdy, vrdy, sv, sh, st;
    logic [7:0]  sf;
    logic [0:0]  sid;
`ifdef NOC_INJ_ERR_DROP_EN
    logic [15:0] err;
`endif

    noc_local_inject_arbiter #(
        .NUM_CH    (2),
        .FLIT_W    (8),
        .FIFO_DEPTH(4)
    ) dut (
        .noc_clk             (clk),
        .noc_rst             (rst),
        .ch_receive_valid    (v),
        .ch_receive_ready    (rrdy),
        .ch_receive_flit     (flits),
        .ch_receive_vc_ready (vcr),
        .ch_receive_is_header(h),
        .ch_receive_is_tail  (t),
        .sender_valid        (sv),
        .sender_ready        (srdy),
        .sender_flit         (sf),
        .sender_vc_ready     (vrdy),
        .sender_is_header    (sh),
        .sender_is_tail      (st),
        .sender_ch_id        (sid)
`ifdef NOC_INJ_ERR_DROP_EN
        ,
        .err_cnt             (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst; logic [1:0] v; logic [7:0] f0, f1; logic [1:0] h, t; logic srdy, vrdy;
        logic ev; logic [7:0] ef; logic eh, et, eid; logic [1:0] er, evc;
    } vec_t;

    vec_t        tbl[$];
    int          n_chk = 0, n_fail = 0, cyc = 0;
    logic [9:0]  src0[$], src1[$];
    logic [10:0] got[$];
    bit          stall_q;
    logic [9:0]  stall_val;

    function automatic vec_t mk(input logic r, input logic [1:0] vv, input logic [7:0] f0,
                                input logic [7:0] f1, input logic [1:0] hh, input logic [1:0] tt,
                                input logic sr, input logic vr, input logic ev,
                                input logic [7:0] ef, input logic eh, input logic et,
                                input logic eid, input logic [1:0] er, input logic [1:0] evc);
        vec_t x;
        x.rst = r; x.v = vv; x.f0 = f0; x.f1 = f1; x.h = hh; x.t = tt; x.srdy = sr; x.vrdy = vr;
        x.ev = ev; x.ef = ef; x.eh = eh; x.et = et; x.eid = eid; x.er = er; x.evc = evc;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; v = '0; h = '0; t = '0; flits = '0; srdy = 1'b1; vrdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        src0.delete(); src1.delete(); got.delete();
        stall_q = 1'b0;
    endtask

    task automatic drive_src();
        if (src0.size() > 0) begin v[0] = 1'b1; {h[0], t[0], flits[7:0]} = src0[0]; end
        else begin v[0] = 1'b0; h[0] = 1'b0; t[0] = 1'b0; flits[7:0] = '0; end
        if (src1.size() > 0) begin v[1] = 1'b1; {h[1], t[1], flits[15:8]} = src1[0]; end
        else begin v[1] = 1'b0; h[1] = 1'b0; t[1] = 1'b0; flits[15:8] = '0; end
    endtask

    // Upstream sources hold each flit until accepted; transfers are logged in got.
    task automatic run(input int cycles, input bit toggle);
        for (int c = 0; c < cycles; c++) begin
            srdy = toggle ? (cyc % 2 == 0) : 1'b1;
            drive_src();
            @(negedge clk);
            if (stall_q) begin
                check("stall_hold_valid", 32'(sv), 32'd1);
                check("stall_hold_flit", 32'({sh, st, sf}), 32'(stall_val));
            end
            if (sv && srdy) got.push_back({sid, sh, st, sf});
            stall_q   = sv && !srdy;
            stall_val = {sh, st, sf};
            if (v[0] && rrdy[0]) void'(src0.pop_front());
            if (v[1] && rrdy[1]) void'(src1.pop_front());
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_got(input string name, input int n, input logic [10:0] exp [5]);
        check({name, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            check($sformatf("%s_%0d", name, i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; v = '0; h = '0; t = '0; flits = '0; srdy = 1'b1; vrdy = 1'b1;
        stall_q = 1'b0; stall_val = '0;

        // Reset with valids high, then single packet ch0 A1/A2/A3.
        tbl.push_back(mk(1, 2'b11, 8'hEE, 8'hEE, 2'b11, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(1, 2'b11, 8'hEE, 8'hEE, 2'b11, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(1, 2'b11, 8'hEE, 8'hEE, 2'b11, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b01, 8'hA1, 8'h00, 2'b01, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0, 2'b11, 2'b11));
        tbl.push_back(mk(0, 2'b01, 8'hA2, 8'h00, 2'b00, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0, 2'b11, 2'b10));
        tbl.push_back(mk(0, 2'b01, 8'hA3, 8'h00, 2'b00, 2'b01, 1, 1, 1, 8'hA1, 1, 0, 0, 2'b11, 2'b10));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1, 1, 8'hA2, 0, 0, 0, 2'b11, 2'b10));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1, 1, 8'hA3, 0, 1, 0, 2'b11, 2'b10));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0, 2'b11, 2'b11));
        // Round robin from reset: two single-flit packets per channel, loaded with vc_ready low.
        tbl.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 0, 0, 8'h00, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b11, 8'hB1, 8'hC1, 2'b11, 2'b11, 1, 0, 0, 8'h00, 0, 0, 0, 2'b11, 2'b11));
        tbl.push_back(mk(0, 2'b11, 8'hB2, 8'hC2, 2'b11, 2'b11, 1, 0, 0, 8'h00, 0, 0, 0, 2'b11, 2'b00));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0, 2'b11, 2'b00));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1, 1, 8'hB1, 1, 1, 0, 2'b11, 2'b00));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0, 2'b11, 2'b00));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1, 1, 8'hC1, 1, 1, 1, 2'b11, 2'b00));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1, 0, 8'h00, 0, 0, 1, 2'b11, 2'b00));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1, 1, 8'hB2, 1, 1, 0, 2'b11, 2'b00));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1, 0, 8'h00, 0, 0, 0, 2'b11, 2'b01));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1, 1, 8'hC2, 1, 1, 1, 2'b11, 2'b01));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1, 1, 0, 8'h00, 0, 0, 1, 2'b11, 2'b11));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; v = tbl[i].v; flits = {tbl[i].f1, tbl[i].f0};
            h = tbl[i].h; t = tbl[i].t; srdy = tbl[i].srdy; vrdy = tbl[i].vrdy;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 32'(sv), 32'(tbl[i].ev));
            check($sformatf("vec%0d_flit", i), 32'(sf), 32'(tbl[i].ef));
            check($sformatf("vec%0d_hdr", i), 32'(sh), 32'(tbl[i].eh));
            check($sformatf("vec%0d_tail", i), 32'(st), 32'(tbl[i].et));
            check($sformatf("vec%0d_ch_id", i), 32'(sid), 32'(tbl[i].eid));
            check($sformatf("vec%0d_ready", i), 32'(rrdy), 32'(tbl[i].er));
            check($sformatf("vec%0d_vc_ready", i), 32'(vcr), 32'(tbl[i].evc));
            @(posedge clk);
            #1;
        end

        // Wormhole lock with toggling sender_ready; ch0 header arrives mid-packet.
        do_reset();
        src1.push_back({2'b10, 8'hD1}); src1.push_back({2'b00, 8'hD2});
        src1.push_back({2'b00, 8'hD3}); src1.push_back({2'b01, 8'hD4});
        run(3, 1'b1);
        src0.push_back({2'b11, 8'hE1});
        run(20, 1'b1);
        check_got("wormhole", 5, '{{3'b110, 8'hD1}, {3'b100, 8'hD2}, {3'b100, 8'hD3},
                                   {3'b101, 8'hD4}, {3'b011, 8'hE1}});

        // Full FIFO while sender_vc_ready is low, then release.
        do_reset();
        vrdy = 1'b0;
        src0.push_back({2'b10, 8'hF1}); src0.push_back({2'b00, 8'hF2});
        src0.push_back({2'b00, 8'hF3}); src0.push_back({2'b00, 8'hF4});
        src0.push_back({2'b01, 8'hF5});
        run(8, 1'b0);
        check("full_ready0", 32'(rrdy[0]), 32'd0);
        check("full_no_grant", 32'(sv), 32'd0);
        check("full_src_left", 32'(src0.size()), 32'd1);
        check("full_no_output", 32'(got.size()), 32'd0);
        vrdy = 1'b1;
        run(15, 1'b0);
        check_got("full_release", 5, '{{3'b010, 8'hF1}, {3'b000, 8'hF2}, {3'b000, 8'hF3},
                                       {3'b000, 8'hF4}, {3'b001, 8'hF5}});

        // Head flit without header mark.
        do_reset();
`ifdef NOC_INJ_ERR_DROP_EN
        check("err_cnt_reset", 32'(err), 32'd0);
        src0.push_back({2'b00, 8'h55}); src0.push_back({2'b10, 8'h66});
        src0.push_back({2'b01, 8'h67});
        run(12, 1'b0);
        check_got("drop", 2, '{{3'b010, 8'h66}, {3'b001, 8'h67}, 11'h0, 11'h0, 11'h0});
        check("err_cnt_one", 32'(err), 32'd1);
`else
        src0.push_back({2'b00, 8'h55});
        src1.push_back({2'b10, 8'h71}); src1.push_back({2'b01, 8'h72});
        run(12, 1'b0);
        check_got("stall", 2, '{{3'b110, 8'h71}, {3'b101, 8'h72}, 11'h0, 11'h0, 11'h0});
        check("stall_ch0_vc_ready", 32'(vcr[0]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
